// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/debug sequencer for the single-cycle CPU (sccomp).
// It gates execution through cpu_en and supports run, halt, N-step and
// one PC breakpoint. It can also pulse the CPU reset and scan the register
// file out through the reg_sel/reg_data debug port.
// Optional build macro CPU_RUN_CTRL_CYCLE_CNT_EN adds a free-running count
// of executed (cpu_en-high) cycles on cycle_cnt; without it cycle_cnt is 0.
module cpu_run_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int STEP_W     = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_arg,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              cpu_en,
  output logic              cpu_rstn,
  output logic [4:0]        reg_sel,
  input  logic [31:0]       reg_data,
  output logic              dump_valid,
  output logic [4:0]        dump_idx,
  output logic [31:0]       dump_data,
  output logic              halted,
  output logic              bp_hit,
  output logic              err,
  output logic [31:0]       cycle_cnt
);

  localparam logic [2:0] OP_HALT      = 3'd0;
  localparam logic [2:0] OP_RUN       = 3'd1;
  localparam logic [2:0] OP_STEP      = 3'd2;
  localparam logic [2:0] OP_SET_BP    = 3'd3;
  localparam logic [2:0] OP_CLR_BP    = 3'd4;
  localparam logic [2:0] OP_DUMP      = 3'd5;
  localparam logic [2:0] OP_CPU_RESET = 3'd6;
  localparam logic [2:0] OP_RSVD      = 3'd7;

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_HALTED,
    ST_RUN,
    ST_STEP,
    ST_DUMP,
    ST_CRST
  } state_t;

  state_t              state;
  logic                bp_valid;
  logic [ADDR_W-1:0]   bp_addr;
  logic                skip_bp;
  logic [STEP_W-1:0]   step_cnt;
  logic [RST_W-1:0]    rst_cnt;
  logic                active;
  logic                bp_match;
  logic                cmd_fire;
  logic [STEP_W-1:0]   step_arg;

  // The CPU only executes in RUN/STEP, and never the instruction sitting on
  // the breakpoint. skip_bp lets a resume step off the breakpoint it stopped at.
  assign active    = (state == ST_RUN) || (state == ST_STEP);
  assign bp_match  = bp_valid && (pc_in == bp_addr) && !skip_bp;
  assign cpu_en    = active && !bp_match;
  assign cpu_rstn  = rstn && (state != ST_CRST);
  assign cmd_ready = (state == ST_HALTED) || active;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign halted    = (state == ST_HALTED);
  assign step_arg  = cmd_arg[STEP_W-1:0];

  // Main sequencer: command decode, breakpoint stop, step counting,
  // register scan-out and timed CPU reset all live in this one FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_HALTED;
      bp_valid   <= 1'b0;
      bp_addr    <= '0;
      skip_bp    <= 1'b0;
      step_cnt   <= '0;
      rst_cnt    <= '0;
      reg_sel    <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      bp_hit     <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= 1'b0;
      dump_valid <= 1'b0;
      if (cpu_en) begin
        skip_bp <= 1'b0;
      end
      case (state)
        ST_HALTED: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_RUN: begin
                state   <= ST_RUN;
                bp_hit  <= 1'b0;
                skip_bp <= 1'b1;
              end
              OP_STEP: begin
                state    <= ST_STEP;
                step_cnt <= (step_arg == '0) ? STEP_W'(1) : step_arg;
                bp_hit   <= 1'b0;
                skip_bp  <= 1'b1;
              end
              OP_SET_BP: begin
                bp_addr  <= cmd_arg;
                bp_valid <= 1'b1;
              end
              OP_CLR_BP: begin
                bp_valid <= 1'b0;
              end
              OP_DUMP: begin
                state   <= ST_DUMP;
                reg_sel <= '0;
              end
              OP_CPU_RESET: begin
                state   <= ST_CRST;
                rst_cnt <= '0;
              end
              OP_RSVD: begin
                err <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        ST_RUN, ST_STEP: begin
          if (cmd_fire && (cmd_op != OP_HALT)) begin
            err <= 1'b1;
          end
          if (bp_match) begin
            state  <= ST_HALTED;
            bp_hit <= 1'b1;
          end else if (cmd_fire && (cmd_op == OP_HALT)) begin
            state <= ST_HALTED;
          end else if (state == ST_STEP) begin
            step_cnt <= step_cnt - STEP_W'(1);
            if (step_cnt == STEP_W'(1)) begin
              state <= ST_HALTED;
            end
          end
        end
        ST_DUMP: begin
          dump_data  <= reg_data;
          dump_idx   <= reg_sel;
          dump_valid <= 1'b1;
          reg_sel    <= reg_sel + 5'd1;
          if (reg_sel == 5'd31) begin
            state <= ST_HALTED;
          end
        end
        ST_CRST: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            state <= ST_HALTED;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        default: begin
          state <= ST_HALTED;
        end
      endcase
    end
  end

`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
  // Counts executed cycles; a CPU reset starts a fresh measurement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= '0;
    end else if (halted && cmd_fire && (cmd_op == OP_CPU_RESET)) begin
      cycle_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: self-checking bench for cpu_run_ctrl. A tiny CPU model
// (PC advances by 4 per enabled cycle, cleared by cpu_rstn) and a register
// file array supply pc_in and reg_data; expectations come from counting
// instructions against step counts and breakpoint distances.
module tb_cpu_run_ctrl;

  localparam int ADDR_W     = 32;
  localparam int STEP_W     = 16;
  localparam int RST_CYCLES = 4;

  localparam logic [2:0] OP_HALT      = 3'd0;
  localparam logic [2:0] OP_RUN       = 3'd1;
  localparam logic [2:0] OP_STEP      = 3'd2;
  localparam logic [2:0] OP_SET_BP    = 3'd3;
  localparam logic [2:0] OP_CLR_BP    = 3'd4;
  localparam logic [2:0] OP_DUMP      = 3'd5;
  localparam logic [2:0] OP_CPU_RESET = 3'd6;
  localparam logic [2:0] OP_RSVD      = 3'd7;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] pc;
  logic        cpu_en;
  logic        cpu_rstn;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        halted;
  logic        bp_hit;
  logic        err;
  logic [31:0] cycle_cnt;

  logic [31:0] regs [32];
  logic        en_s;

  int checks   = 0;
  int failures = 0;

  cpu_run_ctrl #(
    .ADDR_W(ADDR_W),
    .STEP_W(STEP_W),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_arg(cmd_arg),
    .pc_in(pc),
    .cpu_en(cpu_en),
    .cpu_rstn(cpu_rstn),
    .reg_sel(reg_sel),
    .reg_data(reg_data),
    .dump_valid(dump_valid),
    .dump_idx(dump_idx),
    .dump_data(dump_data),
    .halted(halted),
    .bp_hit(bp_hit),
    .err(err),
    .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign reg_data = regs[reg_sel];

  // CPU model: cpu_en is sampled mid-cycle, PC retires one instruction per enabled cycle
  always @(negedge clk) en_s <= cpu_en;

  always @(posedge clk or negedge cpu_rstn) begin
    if (!cpu_rstn) pc <= 32'd0;
    else if (en_s) pc <= pc + 32'd4;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = 32'd0;
  endtask

  task automatic cpu_reset_seq();
    send(OP_CPU_RESET, 32'd0);
    repeat (RST_CYCLES + 2) tick();
  endtask

  task automatic wait_halted(input int max_cycles);
    for (int i = 0; i < max_cycles && halted !== 1'b1; i++) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 32'd0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    repeat (3) tick();
    checks++; if (cpu_rstn !== 1'b0) begin failures++; $display("[TB] FAIL rst_cpu_rstn_low: got %0b expected 0", cpu_rstn); end
    rstn = 1'b1;
    #1;
    checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL rst_halted: got %0b expected 1", halted); end
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_cpu_en: got %0b expected 0", cpu_en); end
    checks++; if (cpu_rstn !== 1'b1) begin failures++; $display("[TB] FAIL rst_cpu_rstn: got %0b expected 1", cpu_rstn); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_cmd_ready: got %0b expected 1", cmd_ready); end
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("[TB] FAIL rst_bp_hit: got %0b expected 0", bp_hit); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err: got %0b expected 0", err); end
    checks++; if (dump_valid !== 1'b0 || dump_idx !== 5'd0 || dump_data !== 32'd0 || reg_sel !== 5'd0) begin failures++; $display("[TB] FAIL rst_dump_regs: got valid=%0b idx=%0d data=%h sel=%0d expected all 0", dump_valid, dump_idx, dump_data, reg_sel); end
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("[TB] FAIL rst_cycle_cnt: got %0d expected 0", cycle_cnt); end
    tick();
  endtask

  // Runs STEP with fixed and random counts; upper arg bits are junk that must be ignored
  task automatic test_step();
    int n;
    int exp_n;
    int en;
    logic [31:0] pc0;
    logic [31:0] arg;
    logic [31:0] exp_pc;
    send(OP_CLR_BP, 32'd0);
    for (int t = 0; t < 7; t++) begin
      if (t == 0) n = 3;
      else if (t == 1) n = 0;
      else n = $urandom_range(0, 12);
      arg   = ($urandom() << 16) | 32'(n);
      exp_n = (n == 0) ? 1 : n;
      pc0   = pc;
      en    = 0;
      send(OP_STEP, arg);
      for (int i = 0; i < exp_n + 6; i++) begin
        @(negedge clk);
        if (cpu_en === 1'b1) en++;
        @(posedge clk);
        #1;
      end
      exp_pc = pc0 + 32'(4 * exp_n);
      checks++; if (en != exp_n) begin failures++; $display("[TB] FAIL step_en_cycles(n=%0d): got %0d expected %0d", n, en, exp_n); end
      checks++; if (pc !== exp_pc) begin failures++; $display("[TB] FAIL step_pc(n=%0d): got %h expected %h", n, pc, exp_pc); end
      checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL step_halted(n=%0d): got %0b expected 1", n, halted); end
    end
  endtask

  task automatic test_breakpoint();
    send(OP_CLR_BP, 32'd0);
    cpu_reset_seq();
    send(OP_SET_BP, 32'h10);
    send(OP_RUN, 32'd0);
    wait_halted(20);
    checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL bp_halted: got %0b expected 1", halted); end
    checks++; if (bp_hit !== 1'b1) begin failures++; $display("[TB] FAIL bp_hit_set: got %0b expected 1", bp_hit); end
    checks++; if (pc !== 32'h10) begin failures++; $display("[TB] FAIL bp_pc: got %h expected 00000010", pc); end
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL bp_cpu_en: got %0b expected 0", cpu_en); end
    send(OP_RUN, 32'd0);
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("[TB] FAIL bp_resume_clear: got %0b expected 0", bp_hit); end
    checks++; if (cpu_en !== 1'b1 || pc !== 32'h10) begin failures++; $display("[TB] FAIL bp_resume_en: got en=%0b pc=%h expected en=1 pc=00000010", cpu_en, pc); end
    repeat (3) tick();
    send(OP_HALT, 32'd0);
    checks++; if (halted !== 1'b1 || cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL halt_stop: got halted=%0b en=%0b expected halted=1 en=0", halted, cpu_en); end
    checks++; if (pc !== 32'h20) begin failures++; $display("[TB] FAIL halt_pc: got %h expected 00000020", pc); end
    // HALT accepted in the very cycle the breakpoint matches
    cpu_reset_seq();
    send(OP_RUN, 32'd0);
    repeat (4) tick();
    send(OP_HALT, 32'd0);
    checks++; if (halted !== 1'b1 || bp_hit !== 1'b1 || pc !== 32'h10) begin failures++; $display("[TB] FAIL halt_and_bp: got halted=%0b bp_hit=%0b pc=%h expected 1 1 00000010", halted, bp_hit, pc); end
    // A cleared breakpoint no longer stops execution
    cpu_reset_seq();
    send(OP_SET_BP, 32'h8);
    send(OP_CLR_BP, 32'd0);
    send(OP_STEP, 32'd5);
    wait_halted(20);
    checks++; if (pc !== 32'd20 || bp_hit !== 1'b0) begin failures++; $display("[TB] FAIL clr_bp: got pc=%h bp_hit=%0b expected pc=00000014 bp_hit=0", pc, bp_hit); end
  endtask

  // Random breakpoint distance against random STEP count or free RUN
  task automatic test_bp_random();
    int k;
    int n;
    int nn;
    bit use_run;
    int exp_en;
    bit exp_hit;
    logic [31:0] exp_pc;
    for (int t = 0; t < 8; t++) begin
      k       = $urandom_range(1, 10);
      n       = $urandom_range(0, 12);
      use_run = 1'($urandom_range(0, 1));
      nn      = (n == 0) ? 1 : n;
      if (use_run) begin
        exp_en  = k;
        exp_hit = 1'b1;
      end else begin
        exp_en  = (k < nn) ? k : nn;
        exp_hit = (k < nn);
      end
      exp_pc = 32'(4 * exp_en);
      cpu_reset_seq();
      send(OP_SET_BP, 32'(4 * k));
      if (use_run) send(OP_RUN, 32'd0);
      else send(OP_STEP, 32'(n));
      wait_halted(40);
      checks++; if (halted !== 1'b1 || pc !== exp_pc || bp_hit !== exp_hit) begin failures++; $display("[TB] FAIL bp_random(k=%0d n=%0d run=%0b): got halted=%0b pc=%h bp_hit=%0b expected halted=1 pc=%h bp_hit=%0b", k, n, use_run, halted, pc, bp_hit, exp_pc, exp_hit); end
    end
  endtask

  task automatic test_dump(input bit use_rand);
    int cnt;
    int first;
    int last;
    for (int i = 0; i < 32; i++) regs[i] = use_rand ? $urandom() : 32'(i * 32'h11);
    send(OP_DUMP, 32'd0);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL dump_ready: got %0b expected 0", cmd_ready); end
    cnt = 0; first = -1; last = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (dump_valid === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        checks++;
        if (dump_idx !== 5'(cnt) || dump_data !== regs[cnt % 32]) begin failures++; $display("[TB] FAIL dump_word(%0d): got idx=%0d data=%h expected idx=%0d data=%h", cnt, dump_idx, dump_data, cnt % 32, regs[cnt % 32]); end
        cnt++;
      end
    end
    checks++; if (cnt != 32 || first != 1 || last != 32) begin failures++; $display("[TB] FAIL dump_window: got count=%0d first=%0d last=%0d expected 32 1 32", cnt, first, last); end
    checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL dump_halted: got %0b expected 1", halted); end
  endtask

  task automatic test_cpu_reset();
    int low;
    int bad_ready;
    send(OP_CLR_BP, 32'd0);
    send(OP_SET_BP, 32'h8);
    send(OP_CPU_RESET, 32'd0);
    low = 0; bad_ready = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_rstn === 1'b0) begin
        low++;
        if (cmd_ready !== 1'b0) bad_ready++;
      end
      tick();
    end
    checks++; if (low != RST_CYCLES) begin failures++; $display("[TB] FAIL crst_low_cycles: got %0d expected %0d", low, RST_CYCLES); end
    checks++; if (bad_ready != 0) begin failures++; $display("[TB] FAIL crst_ready: got %0d ready cycles expected 0", bad_ready); end
    checks++; if (halted !== 1'b1 || pc !== 32'd0) begin failures++; $display("[TB] FAIL crst_end: got halted=%0b pc=%h expected 1 00000000", halted, pc); end
    send(OP_RUN, 32'd0);
    wait_halted(20);
    checks++; if (bp_hit !== 1'b1 || pc !== 32'h8) begin failures++; $display("[TB] FAIL crst_bp_kept: got bp_hit=%0b pc=%h expected 1 00000008", bp_hit, pc); end
  endtask

  task automatic test_halt_long_step();
    logic [31:0] exp_cc;
    send(OP_CLR_BP, 32'd0);
    cpu_reset_seq();
    send(OP_STEP, 32'h1000);
    repeat (9) tick();
    send(OP_HALT, 32'd0);
    checks++; if (halted !== 1'b1 || cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL long_step_halt: got halted=%0b en=%0b expected 1 0", halted, cpu_en); end
    repeat (3) tick();
    checks++; if (pc !== 32'd40) begin failures++; $display("[TB] FAIL long_step_pc: got %h expected 00000028", pc); end
`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
    exp_cc = 32'd10;
`else
    exp_cc = 32'd0;
`endif
    checks++; if (cycle_cnt !== exp_cc) begin failures++; $display("[TB] FAIL cycle_cnt: got %0d expected %0d", cycle_cnt, exp_cc); end
  endtask

  task automatic test_err();
    send(OP_CLR_BP, 32'd0);
    send(OP_RUN, 32'd0);
    tick();
    send(OP_RUN, 32'd0);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL err_run_in_run: got %0b expected 1", err); end
    checks++; if (halted !== 1'b0 || cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL err_stays_run: got halted=%0b en=%0b expected 0 1", halted, cpu_en); end
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL err_pulse_width: got %0b expected 0", err); end
    send(OP_HALT, 32'd0);
    checks++; if (err !== 1'b0 || halted !== 1'b1) begin failures++; $display("[TB] FAIL err_halt_legal: got err=%0b halted=%0b expected 0 1", err, halted); end
    send(OP_RSVD, 32'd0);
    checks++; if (err !== 1'b1 || halted !== 1'b1) begin failures++; $display("[TB] FAIL err_rsvd: got err=%0b halted=%0b expected 1 1", err, halted); end
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL err_rsvd_width: got %0b expected 0", err); end
  endtask

  task automatic test_async_reset();
    send(OP_CLR_BP, 32'd0);
    cpu_reset_seq();
    send(OP_SET_BP, 32'h40);
    send(OP_RUN, 32'd0);
    repeat (2) tick();
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (cpu_en !== 1'b0 || halted !== 1'b1 || cpu_rstn !== 1'b0) begin failures++; $display("[TB] FAIL async_rst: got en=%0b halted=%0b cpu_rstn=%0b expected 0 1 0", cpu_en, halted, cpu_rstn); end
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    send(OP_STEP, 32'd20);
    wait_halted(40);
    checks++; if (pc !== 32'd80 || bp_hit !== 1'b0) begin failures++; $display("[TB] FAIL async_rst_bp_cleared: got pc=%h bp_hit=%0b expected 00000050 0", pc, bp_hit); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_breakpoint();
    test_bp_random();
    test_dump(1'b0);
    test_dump(1'b1);
    test_cpu_reset();
    test_halt_long_step();
    test_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/debug controller that sequences the single-cycle CPU (sccomp).
- Gates instruction execution through a PC-update enable and supports run, halt, single/N-step and one PC breakpoint.
- Pulses the CPU reset and scans the register file out through the CPU's reg_sel/reg_data debug port.
- Sits between a host command source (UART/bench) and sccomp.

Parameters:
- ADDR_W, 32, width of PC and breakpoint address.
- STEP_W, 16, width of step count argument/counter.
- RST_CYCLES, 4, cycles cpu_rstn held low by CPU_RESET (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_op  in  3  0 HALT, 1 RUN, 2 STEP, 3 SET_BP, 4 CLR_BP, 5 DUMP, 6 CPU_RESET, 7 reserved.
- cmd_arg  in  ADDR_W  STEP count (low STEP_W bits) or breakpoint address.
- pc_in  in  ADDR_W  current CPU PC.
- cpu_en  out  1  CPU PC/regfile write enable.
- cpu_rstn  out  1  CPU reset, active low.
- reg_sel  out  5  register index to CPU debug port.
- reg_data  in  32  register value from CPU (combinational).
- dump_valid  out  1  dump word valid.
- dump_idx  out  5  register index of dump word.
- dump_data  out  32  dump word.
- halted  out  1  state==HALTED.
- bp_hit  out  1  sticky, set on breakpoint stop.
- err  out  1  one-cycle pulse on illegal command.
- cycle_cnt  out  32  see Optional Feature.

Behaviour:
- States: HALTED, RUN, STEP, DUMP, CRST. Reset → HALTED.
- Reset values: cpu_en=0, reg_sel=0, dump_valid=0, dump_idx=0, dump_data=0, bp_hit=0, err=0, bp_valid=0, bp_addr=0, counters=0.
- cpu_rstn = rstn && state!=CRST (combinational).
- cmd_ready = 1 in HALTED, RUN, STEP; 0 in DUMP, CRST.
- HALTED accepts:
  - RUN → RUN; clears bp_hit; sets skip_bp.
  - STEP → STEP; count=arg, 0 treated as 1; clears bp_hit; sets skip_bp.
  - SET_BP: bp_addr=arg, bp_valid=1.
  - CLR_BP: bp_valid=0.
  - DUMP → DUMP.
  - CPU_RESET → CRST.
  - op 7: err pulse.
- RUN/STEP accept HALT only: → HALTED next edge; cpu_en is 0 from the edge after acceptance. Any other op in RUN/STEP: accepted, ignored, err pulses next cycle.
- bp_match = bp_valid && pc_in==bp_addr && !skip_bp.
- skip_bp clears after the first enabled cycle.
- cpu_en = (RUN||STEP) && !bp_match, combinational. The breakpoint instruction is not executed.
- On bp_match in RUN or STEP: → HALTED, bp_hit=1.
- STEP: count decrements on every enabled cycle; after the enabled cycle with count==1 → HALTED. Exactly N enabled cycles unless a breakpoint or HALT intervenes.
- DUMP: idx counts 0..31; reg_sel=idx.
  - Each cycle: dump_data<=reg_data, dump_idx<=idx, dump_valid<=1.
  - After idx 31 → HALTED.
  - dump_valid is high exactly 32 consecutive cycles, starting the cycle after entry.
- CRST: cpu_rstn low exactly RST_CYCLES cycles, then → HALTED. bp registers are preserved.
- Simultaneous HALT accept and bp_match: result is HALTED with bp_hit=1.
- Async rstn mid-operation: immediate return to reset values; cpu_en drops at once.

Optional Feature:
- Macro CPU_RUN_CTRL_CYCLE_CNT_EN.
- Defined: cycle_cnt is a 32-bit counter of cpu_en-high cycles. It wraps at 2^32, clears on rstn and on CPU_RESET entry.
- Undefined: cycle_cnt tied to 0 and no counter logic.

Test Plan:
- Reset → halted=1, cpu_en=0, cpu_rstn=1, cmd_ready=1, bp_hit=0.
- STEP arg=3 → cpu_en high exactly 3 cycles, then halted=1; STEP arg=0 → exactly 1 cycle.
- SET_BP 0x10, RUN, pc_in 0,4,8,0xC,0x10 → cpu_en low when pc_in=0x10, halted=1, bp_hit=1; RUN again → cpu_en high with pc_in=0x10, bp_hit=0.
- Regfile model reg[i]=i*0x11, DUMP → 32 dump_valid cycles, dump_idx 0..31, dump_data=i*0x11, then halted.
- CPU_RESET → cpu_rstn low exactly 4 cycles, cmd_ready=0 throughout, then halted=1.
- STEP 0x1000, HALT after 10 cycles → exactly 10 enabled cycles; in RUN, RUN cmd → err 1-cycle pulse, state stays RUN; with macro, cycle_cnt=10 after the halt.
